// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: 1-cycle decode register, 2-entry skid, saturating illegal counter.
// Optional build macro IMMGEN_CSR_EN enables decoding of SYSTEM (CSR) instructions.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] ill_cnt,
    input  logic             cnt_clr
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
`ifdef IMMGEN_CSR_EN
    localparam logic [2:0] FMT_Z = 3'd6;
`endif

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [31:0]     instr;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] instr);
        entry_t     e;
        logic [31:0] imm32;
        e         = '0;
        imm32     = '0;
        e.instr   = instr;
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                e.fmt = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0100011: begin
                e.fmt = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                e.fmt = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            7'b1101111: begin
                e.fmt = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
`ifdef IMMGEN_CSR_EN
            7'b1110011: begin
                // funct3[2] selects the immediate-operand CSR forms (rs1 field is a uimm)
                if (instr[14]) begin
                    e.fmt = FMT_Z;
                    imm32 = {27'b0, instr[19:15]};
                end else begin
                    e.fmt = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
            end
`endif
            7'b0110011: e.fmt = FMT_R;
            default:    e.illegal = 1'b1;
        endcase
        // imm32 is already sign-correct; the signed cast fills the remaining XLEN bits
        e.imm = XLEN'($signed(imm32));
        return e;
    endfunction

    entry_t            dec;
    entry_t            out_reg;
    entry_t            skid_reg;
    logic              out_valid_reg;
    logic              skid_valid_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              accept;
    logic              load_out;

    always_comb begin
        dec      = decode(in_instr);
        accept   = in_valid && !skid_valid_reg;
        load_out = out_ready || !out_valid_reg;
    end

    // Output stage and skid: the skid only fills while the output is stalled,
    // so in_ready can come straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_reg        <= '0;
            skid_valid_reg <= 1'b0;
            skid_reg       <= '0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (load_out) begin
            if (skid_valid_reg) begin
                out_reg        <= skid_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= accept;
                if (accept) begin
                    out_reg <= dec;
                end
            end
        end else if (accept) begin
            skid_reg       <= dec;
            skid_valid_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_clr) begin
            cnt_reg <= '0;
        end else if (out_valid_reg && out_ready && out_reg.illegal && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign in_ready    = !skid_valid_reg;
    assign out_valid   = out_valid_reg;
    assign out_imm     = out_reg.imm;
    assign out_fmt     = out_reg.fmt;
    assign out_illegal = out_reg.illegal;
    assign out_instr   = out_reg.instr;
    assign ill_cnt     = cnt_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32/CNT_W=2 and XLEN=64/CNT_W=16 instances share one stimulus,
// checked each cycle against a 2-deep FIFO model plus literal expectations.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        r32_in_ready, r32_out_valid, r32_out_illegal;
    logic [31:0] r32_out_imm, r32_out_instr;
    logic [2:0]  r32_out_fmt;
    logic [1:0]  r32_ill_cnt;

    logic        r64_in_ready, r64_out_valid, r64_out_illegal;
    logic [63:0] r64_out_imm;
    logic [31:0] r64_out_instr;
    logic [2:0]  r64_out_fmt;
    logic [15:0] r64_ill_cnt;

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32_in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(r32_out_valid), .out_ready(out_ready),
        .out_imm(r32_out_imm), .out_fmt(r32_out_fmt), .out_illegal(r32_out_illegal),
        .out_instr(r32_out_instr), .ill_cnt(r32_ill_cnt), .cnt_clr(cnt_clr)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64_in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(r64_out_valid), .out_ready(out_ready),
        .out_imm(r64_out_imm), .out_fmt(r64_out_fmt), .out_illegal(r64_out_illegal),
        .out_instr(r64_out_instr), .ill_cnt(r64_ill_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [63:0] imm;
        int          fmt;
        bit          ill;
    } exp_t;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } lit_t;

    // Immediate value from the ISA field layout, using plain integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t   e;
        longint v;
        e.imm = '0;
        e.fmt = 0;
        e.ill = 1'b0;
        v     = 0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: begin
                v = longint'(w[31:20]);
                if (v >= 2048) v -= 4096;
                e.fmt = 1;
            end
            7'h23: begin
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                if (v >= 2048) v -= 4096;
                e.fmt = 2;
            end
            7'h63: begin
                v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                if (v >= 4096) v -= 8192;
                e.fmt = 3;
            end
            7'h37, 7'h17: begin
                v = longint'(w[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
                e.fmt = 4;
            end
            7'h6F: begin
                v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
                e.fmt = 5;
            end
            7'h33: e.fmt = 0;
`ifdef IMMGEN_CSR_EN
            7'h73: begin
                if (w[14]) begin
                    v = longint'(w[19:15]);
                    e.fmt = 6;
                end else begin
                    v = longint'(w[31:20]);
                    if (v >= 2048) v -= 4096;
                    e.fmt = 1;
                end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.imm = 64'(v);
        return e;
    endfunction

    function automatic logic [63:0] pick(input int sel);
        case (sel)
            0:  pick = 64'(r32_out_valid);
            1:  pick = 64'(r32_in_ready);
            2:  pick = 64'(r32_out_imm);
            3:  pick = 64'(r32_out_fmt);
            4:  pick = 64'(r32_out_illegal);
            5:  pick = 64'(r32_out_instr);
            6:  pick = 64'(r32_ill_cnt);
            10: pick = 64'(r64_out_valid);
            11: pick = 64'(r64_in_ready);
            12: pick = r64_out_imm;
            13: pick = 64'(r64_out_fmt);
            14: pick = 64'(r64_out_illegal);
            15: pick = 64'(r64_out_instr);
            16: pick = 64'(r64_ill_cnt);
            default: pick = 'x;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Literal expectations queued by the stimulus, checked at the next falling edge
    lit_t lits[$];

    task automatic expect_lit(input string name, input int sel, input logic [63:0] exp);
        lit_t l;
        l.name = name;
        l.sel  = sel;
        l.exp  = exp;
        lits.push_back(l);
    endtask

    logic        s_rst_n = 1'b0;
    logic        s_in_valid = 1'b0;
    logic [31:0] s_in_instr = '0;
    logic        s_out_ready = 1'b0;
    logic        s_flush = 1'b0;
    logic        s_cnt_clr = 1'b0;

    always @(posedge clk) begin
        s_rst_n     <= rst_n;
        s_in_valid  <= in_valid;
        s_in_instr  <= in_instr;
        s_out_ready <= out_ready;
        s_flush     <= flush;
        s_cnt_clr   <= cnt_clr;
    end

    // Model: the block behaves as a 2-deep FIFO whose head is the output register.
    logic [31:0] q[$];
    int          m_cnt32 = 0;
    int          m_cnt64 = 0;
    bit          m_deliver, m_accept;
    exp_t        m_e;
    lit_t        m_l;

    always @(negedge clk) begin
        if (!rst_n || !s_rst_n) begin
            q.delete();
            m_cnt32 = 0;
            m_cnt64 = 0;
        end else begin
            m_deliver = (q.size() != 0) && s_out_ready;
            m_accept  = s_in_valid && (q.size() < 2);
            if (s_cnt_clr) begin
                m_cnt32 = 0;
                m_cnt64 = 0;
            end else if (m_deliver) begin
                m_e = ref_decode(q[0]);
                if (m_e.ill) begin
                    if (m_cnt32 < 3)     m_cnt32++;
                    if (m_cnt64 < 65535) m_cnt64++;
                end
            end
            if (s_flush) begin
                q.delete();
            end else begin
                if (m_deliver) void'(q.pop_front());
                if (m_accept)  q.push_back(s_in_instr);
            end
        end
        chk("valid32", 64'(r32_out_valid), 64'(q.size() != 0));
        chk("valid64", 64'(r64_out_valid), 64'(q.size() != 0));
        chk("ready32", 64'(r32_in_ready), 64'(q.size() < 2));
        chk("ready64", 64'(r64_in_ready), 64'(q.size() < 2));
        chk("cnt32", 64'(r32_ill_cnt), 64'(m_cnt32));
        chk("cnt64", 64'(r64_ill_cnt), 64'(m_cnt64));
        if (q.size() != 0) begin
            m_e = ref_decode(q[0]);
            chk("imm32", 64'(r32_out_imm), 64'(m_e.imm[31:0]));
            chk("imm64", r64_out_imm, m_e.imm);
            chk("fmt32", 64'(r32_out_fmt), 64'(m_e.fmt));
            chk("fmt64", 64'(r64_out_fmt), 64'(m_e.fmt));
            chk("ill32", 64'(r32_out_illegal), 64'(m_e.ill));
            chk("ill64", 64'(r64_out_illegal), 64'(m_e.ill));
            chk("instr32", 64'(r32_out_instr), 64'(q[0]));
            chk("instr64", 64'(r64_out_instr), 64'(q[0]));
        end
        while (lits.size() != 0) begin
            m_l = lits.pop_front();
            chk(m_l.name, pick(m_l.sel), m_l.exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w);
        in_valid = 1'b1;
        in_instr = w;
        step();
        in_valid = 1'b0;
    endtask

    logic [6:0]  ops[10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73};
    logic [31:0] rw;
    int          bias;

    initial begin
        // Reset values
        out_ready = 1'b1;
        step();
        expect_lit("rst_valid", 0, 64'h0);
        expect_lit("rst_ready", 1, 64'h1);
        expect_lit("rst_imm", 12, 64'h0);
        expect_lit("rst_fmt", 3, 64'h0);
        expect_lit("rst_ill", 4, 64'h0);
        expect_lit("rst_instr", 5, 64'h0);
        expect_lit("rst_cnt", 16, 64'h0);
        step();
        rst_n = 1'b1;
        step();

        // Basic decode, back-to-back at full throughput
        offer(32'hFFF00093);
        expect_lit("addi_imm", 2, 64'hFFFF_FFFF);
        expect_lit("addi_fmt", 3, 64'd1);
        expect_lit("addi_ill", 4, 64'd0);
        offer(32'hFE000EE3);
        expect_lit("beq_imm", 2, 64'hFFFF_FFFC);
        expect_lit("beq_fmt", 3, 64'd3);
        offer(32'h0080006F);
        expect_lit("jal_imm", 2, 64'h0000_0008);
        expect_lit("jal_fmt", 3, 64'd5);
        offer(32'h800000B7);
        expect_lit("lui64_imm", 12, 64'hFFFF_FFFF_8000_0000);
        expect_lit("lui64_fmt", 13, 64'd4);
        offer(32'h123450B7);
        expect_lit("lui64b_imm", 12, 64'h0000_0000_1234_5000);
        step();

        // Stall with skid full, then drain in order
        offer(32'h00500093);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h123450B7;
        step();
        in_instr  = 32'hFE000EE3;
        step();
        step();
        expect_lit("stall_instr", 5, 64'h0050_0093);
        expect_lit("stall_ready", 1, 64'd0);
        expect_lit("stall_valid", 0, 64'd1);
        out_ready = 1'b1;
        step();
        expect_lit("drain_b", 5, 64'h1234_50B7);
        expect_lit("drain_rdy", 1, 64'd1);
        step();
        expect_lit("drain_c", 5, 64'hFE00_0EE3);
        in_valid = 1'b0;
        step();
        expect_lit("drain_empty", 0, 64'd0);

        // Saturating counter with CNT_W=2, then clear beating a delivery
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(32'h0000007F);
            expect_lit("ill_flag", 4, 64'd1);
        end
        step();
        expect_lit("sat_cnt32", 6, 64'd3);
        expect_lit("sat_cnt64", 16, 64'd5);
        offer(32'h0000007F);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        expect_lit("clr_cnt32", 6, 64'd0);
        expect_lit("clr_cnt64", 16, 64'd0);

        // Flush with stalled output and full skid, input offered alongside
        offer(32'h0000007F);
        offer(32'h0000007F);
        out_ready = 1'b0;
        offer(32'h00100093);
        expect_lit("pre_flush_rdy", 1, 64'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00200093;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        expect_lit("flush_valid", 0, 64'd0);
        expect_lit("flush_ready", 1, 64'd1);
        expect_lit("flush_cnt", 6, 64'd1);
        out_ready = 1'b1;
        step();
        expect_lit("flush_drop", 0, 64'd0);
        expect_lit("flush_cnt2", 16, 64'd1);

        // CSR instructions
        offer(32'h30529073);
`ifdef IMMGEN_CSR_EN
        expect_lit("csrw_fmt", 3, 64'd1);
        expect_lit("csrw_imm", 2, 64'h305);
`else
        expect_lit("csrw_ill", 4, 64'd1);
        expect_lit("csrw_imm", 2, 64'h0);
`endif
        offer(32'h3052D073);
`ifdef IMMGEN_CSR_EN
        expect_lit("csrwi_fmt", 3, 64'd6);
        expect_lit("csrwi_imm", 12, 64'h5);
`else
        expect_lit("csrwi_ill", 4, 64'd1);
        expect_lit("csrwi_imm", 12, 64'h0);
`endif
        step();

        // Randomized traffic, with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            bias = (i / 500) % 3;
            rw = $urandom;
            if ($urandom_range(0, 7) != 0) rw[6:0] = ops[$urandom_range(0, 9)];
            in_instr  = rw;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (bias == 0) ? 1'b1 : (bias == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            cnt_clr   = ($urandom_range(0, 80) == 0);
            step();
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
        end

        in_valid  = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
